// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory lane sequencer.
// misaligned() is only used when MEM_SEQ_LOAD_EXT_EN is defined.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } seq_state_t;

    localparam logic [1:0] MSIZE_B = 2'd0;
    localparam logic [1:0] MSIZE_H = 2'd1;
    localparam logic [1:0] MSIZE_W = 2'd2;

    // Index of the lowest set bit, or 8 when no bit is set (groups never exceed 8 lanes).
    function automatic int lowestSet(input logic [7:0] v);
        int idx;
        idx = 8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MSIZE_B: return 1'b0;
            MSIZE_H: return offset[0];
            MSIZE_W: return offset != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_sequencer_if.sv
// Group/bus signal bundle for mem_lane_sequencer. The slave modport is the sequencer;
// the master modport is its environment. lane_signed exists only with MEM_SEQ_LOAD_EXT_EN.
interface mem_lane_sequencer_if #(
    parameter int LANES = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       lane_req;
    logic [LANES-1:0]       lane_wr;
    logic [LANES-1:0]       lane_fault;
    logic [LANES*AW-1:0]    lane_addr;
    logic [LANES*2-1:0]     lane_size;
    logic [LANES*DW/8-1:0]  lane_strobe;
    logic [LANES*DW-1:0]    lane_wdata;
`ifdef MEM_SEQ_LOAD_EXT_EN
    logic [LANES-1:0]       lane_signed;
`endif
    logic                   flush;
    logic                   dreq_valid;
    logic [AW-1:0]          dreq_addr;
    logic [1:0]             dreq_size;
    logic [DW/8-1:0]        dreq_strobe;
    logic [DW-1:0]          dreq_data;
    logic                   dresp_addr_ok;
    logic                   dresp_data_ok;
    logic [DW-1:0]          dresp_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*DW-1:0]    lane_rdata;
    logic [LANES-1:0]       lane_kill;
    logic                   exception_valid;

    modport slave (
        input  in_valid, lane_req, lane_wr, lane_fault, lane_addr, lane_size,
               lane_strobe, lane_wdata,
`ifdef MEM_SEQ_LOAD_EXT_EN
               lane_signed,
`endif
               flush, dresp_addr_ok, dresp_data_ok, dresp_data, out_ready,
        output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
               out_valid, lane_rdata, lane_kill, exception_valid
    );

    modport master (
        output in_valid, lane_req, lane_wr, lane_fault, lane_addr, lane_size,
               lane_strobe, lane_wdata,
`ifdef MEM_SEQ_LOAD_EXT_EN
               lane_signed,
`endif
               flush, dresp_addr_ok, dresp_data_ok, dresp_data, out_ready,
        input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
               out_valid, lane_rdata, lane_kill, exception_valid
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load extraction: selects the addressed byte/half/word and sign- or zero-extends it.
// Instantiated by mem_lane_sequencer only when MEM_SEQ_LOAD_EXT_EN is defined.
module mem_load_align
    import mem_seq_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    i_offset,
    input  logic [1:0]    i_size,
    input  logic          i_signed,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);
    logic [DW-1:0] w_shifted;

    assign w_shifted = i_data >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_size)
            MSIZE_B: o_data = {{(DW-8){i_signed & w_shifted[7]}}, w_shifted[7:0]};
            MSIZE_H: o_data = {{(DW-16){i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_lane_sequencer.sv
// Serialises one issue group of memory ops onto a single data bus in lane order, then hands results on.
// Define MEM_SEQ_LOAD_EXT_EN for load extraction/extension and misalignment faults.
module mem_lane_sequencer
    import mem_seq_pkg::*;
#(
    parameter int LANES = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic                  clk,
    input logic                  resetn,
    mem_lane_sequencer_if.slave  bus
);
    localparam int SW = DW / 8;
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    seq_state_t r_state, w_nextState;

    logic [LANES-1:0] r_pending, r_kill, r_wr;
    logic             r_flushed, r_exc;
    logic [AW-1:0]    r_addr   [LANES];
    logic [1:0]       r_size   [LANES];
    logic [SW-1:0]    r_strobe [LANES];
    logic [DW-1:0]    r_wdata  [LANES];
    logic [DW-1:0]    r_rdata  [LANES];
`ifdef MEM_SEQ_LOAD_EXT_EN
    logic [LANES-1:0] r_signed;
`endif

    logic [LANES-1:0] w_fault, w_capKill, w_capPending, w_pendingAfter;
    logic [PW-1:0]    w_ptr;
    logic             w_capture, w_flushNow, w_complete, w_dropData;
    logic [DW-1:0]    w_loadData;

    always_comb begin
        w_fault = bus.lane_fault;
`ifdef MEM_SEQ_LOAD_EXT_EN
        for (int i = 0; i < LANES; i++) begin
            if (bus.lane_req[i] && misaligned(bus.lane_size[2*i +: 2], bus.lane_addr[i*AW +: 2]))
                w_fault[i] = 1'b1;
        end
`endif
    end

    // Lanes younger than the first fault are squashed; the faulting lane itself is only suppressed.
    always_comb begin
        w_capKill = '0;
        for (int i = 0; i < LANES; i++) begin
            w_capKill[i] = bus.flush || (i > lowestSet(8'(w_fault)));
        end
        w_capPending = bus.lane_req & ~w_capKill & ~w_fault;
    end

    assign w_ptr        = PW'(lowestSet(8'(r_pending)));
    assign bus.in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_capture    = bus.in_valid && bus.in_ready;
    assign w_flushNow   = bus.flush && ((r_state == ISSUE) || (r_state == WAIT_DATA));
    assign w_complete   = ((r_state == ISSUE) && bus.dresp_addr_ok && bus.dresp_data_ok) ||
                          ((r_state == WAIT_DATA) && bus.dresp_data_ok);
    assign w_dropData   = r_flushed || bus.flush;

    always_comb begin
        w_pendingAfter        = r_pending;
        w_pendingAfter[w_ptr] = 1'b0;
    end

`ifdef MEM_SEQ_LOAD_EXT_EN
    mem_load_align #(.DW(DW)) u_align (
        .i_offset (r_addr[w_ptr][1:0]),
        .i_size   (r_size[w_ptr]),
        .i_signed (r_signed[w_ptr]),
        .i_data   (bus.dresp_data),
        .o_data   (w_loadData)
    );
`else
    assign w_loadData = bus.dresp_data;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    // A flush never withdraws an accepted request; it only stops the lanes behind it.
    always_comb begin
        w_nextState     = r_state;
        bus.dreq_valid  = 1'b0;
        bus.dreq_addr   = '0;
        bus.dreq_size   = '0;
        bus.dreq_strobe = '0;
        bus.dreq_data   = '0;
        bus.out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_capture) w_nextState = (|w_capPending) ? ISSUE : DONE;
            end
            ISSUE: begin
                bus.dreq_valid  = 1'b1;
                bus.dreq_addr   = r_addr[w_ptr];
                bus.dreq_size   = r_size[w_ptr];
                bus.dreq_strobe = r_strobe[w_ptr];
                bus.dreq_data   = r_wdata[w_ptr];
                if (bus.dresp_addr_ok) begin
                    if (bus.dresp_data_ok)
                        w_nextState = (w_dropData || (w_pendingAfter == '0)) ? DONE : ISSUE;
                    else
                        w_nextState = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.dresp_data_ok)
                    w_nextState = (w_dropData || (w_pendingAfter == '0)) ? DONE : ISSUE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (w_capture)          w_nextState = (|w_capPending) ? ISSUE : DONE;
                else if (bus.out_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pending <= '0;
            r_kill    <= '0;
            r_wr      <= '0;
            r_flushed <= 1'b0;
            r_exc     <= 1'b0;
`ifdef MEM_SEQ_LOAD_EXT_EN
            r_signed  <= '0;
`endif
            for (int i = 0; i < LANES; i++) begin
                r_addr[i]   <= '0;
                r_size[i]   <= '0;
                r_strobe[i] <= '0;
                r_wdata[i]  <= '0;
                r_rdata[i]  <= '0;
            end
        end else if (w_capture) begin
            r_pending <= w_capPending;
            r_kill    <= w_capKill;
            r_wr      <= bus.lane_wr;
            r_flushed <= 1'b0;
            r_exc     <= |w_fault;
`ifdef MEM_SEQ_LOAD_EXT_EN
            r_signed  <= bus.lane_signed;
`endif
            for (int i = 0; i < LANES; i++) begin
                r_addr[i]   <= bus.lane_addr[i*AW +: AW];
                r_size[i]   <= bus.lane_size[2*i +: 2];
                r_strobe[i] <= bus.lane_strobe[i*SW +: SW];
                r_wdata[i]  <= bus.lane_wdata[i*DW +: DW];
                r_rdata[i]  <= '0;
            end
        end else begin
            if (w_flushNow) begin
                r_kill    <= r_kill | r_pending;
                r_flushed <= 1'b1;
            end
            if (w_complete) begin
                r_pending[w_ptr] <= 1'b0;
                if (!r_wr[w_ptr] && !w_dropData) r_rdata[w_ptr] <= w_loadData;
            end
        end
    end

    always_comb begin
        bus.lane_rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.lane_rdata[i*DW +: DW] = r_rdata[i];
        end
    end

    assign bus.lane_kill       = r_kill;
    assign bus.exception_valid = r_exc;

endmodule
